// File: rtl/vga_bus_arbiter.sv
// vga_bus_arbiter
// CPU bus front end and video RAM arbiter for the mini VGA card.
// CPU I/O writes are synchronized into clk and decoded into an address
// pointer, a write FIFO and a control register. A single-port video RAM is
// shared between pixel fetches (highest priority), a clear-screen sequencer
// and FIFO drains.
//
// Ports:
//   clk, rst                 pixel clock, async active-high reset
//   iorq, write              CPU strobe (asynchronous to clk)
//   chipsel, data            register select / write data
//   prepline                 blocks clear and FIFO traffic while high
//   pix_req, pix_addr        pixel read request / address
//   pix_gnt                  read accepted (equals pix_req)
//   pix_rdata, pix_rvalid    read return
//   mem_addr/wdata/we/re     registered RAM command
//   mem_rdata                RAM read data, one cycle after mem_re
//   display_en, busy, overflow  status
module vga_bus_arbiter #(
   parameter int ADDR_BITS  = 13,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 iorq,
   input  logic                 write,
   input  logic [1:0]           chipsel,
   input  logic [7:0]           data,
   input  logic                 prepline,
   input  logic                 pix_req,
   input  logic [ADDR_BITS-1:0] pix_addr,
   output logic                 pix_gnt,
   output logic [7:0]           pix_rdata,
   output logic                 pix_rvalid,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 mem_we,
   output logic                 mem_re,
   input  logic [7:0]           mem_rdata,
   output logic                 display_en,
   output logic                 busy,
   output logic                 overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int EW = ADDR_BITS + 8;

   logic                 s_meta, s_sync, s_prev;
   logic                 bus_evt;
   logic [ADDR_BITS-1:0] addr_ptr, addr_next;
   logic [ADDR_BITS-1:0] clr_ptr;
   logic                 clr_active;
   logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
   logic [PW:0]          wr_ptr, rd_ptr;
   logic                 fifo_empty, fifo_full;
   logic [EW-1:0]        fifo_head;
   logic                 grant_clr, grant_fifo;
   logic                 push_evt, push_ok;
   logic [7:0]           rdata_q;

   assign pix_gnt = pix_req;

   // Read data only exists on mem_rdata during the rvalid cycle, so it is
   // passed through then and held from a register afterwards.
   assign pix_rdata = pix_rvalid ? mem_rdata : rdata_q;

   assign bus_evt    = s_sync & ~s_prev;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign fifo_head  = fifo_mem[rd_ptr[PW-1:0]];

   always_comb begin
      grant_clr  = !pix_req && clr_active && !prepline;
      grant_fifo = !pix_req && !clr_active && !fifo_empty && !prepline;
      push_evt   = bus_evt && (chipsel == 2'd2);
      // A full FIFO still accepts if the head leaves in the same cycle.
      push_ok    = push_evt && (!fifo_full || grant_fifo);
   end

   // Reg 0 loads bits 7:0, reg 1 loads bits 15:8; bits beyond the address
   // width fall away naturally.
   always_comb begin
      addr_next = addr_ptr;
      for (int i = 0; i < ADDR_BITS; i++) begin
         if (bus_evt && chipsel == 2'd0 && i < 8)
            addr_next[i] = data[i % 8];
         if (bus_evt && chipsel == 2'd1 && i >= 8 && i < 16)
            addr_next[i] = data[i % 8];
      end
      if (push_evt)
         addr_next = addr_ptr + ADDR_BITS'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr[PW-1:0]] <= {addr_ptr, data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_meta     <= 1'b0;
         s_sync     <= 1'b0;
         s_prev     <= 1'b0;
         addr_ptr   <= '0;
         clr_ptr    <= '0;
         clr_active <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         pix_rvalid <= 1'b0;
         rdata_q    <= '0;
         display_en <= 1'b0;
         busy       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         s_meta   <= iorq & write;
         s_sync   <= s_meta;
         s_prev   <= s_sync;
         addr_ptr <= addr_next;

         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         else if (push_evt)
            overflow <= 1'b1;

         if (bus_evt && chipsel == 2'd3) begin
            display_en <= data[0];
            if (data[1] && !clr_active) begin
               clr_active <= 1'b1;
               clr_ptr    <= '0;
            end
            if (data[7])
               overflow <= 1'b0;
         end

         mem_we <= 1'b0;
         mem_re <= 1'b0;
         if (pix_req) begin
            mem_addr <= pix_addr;
            mem_re   <= 1'b1;
         end else if (grant_clr) begin
            mem_addr  <= clr_ptr;
            mem_wdata <= 8'h00;
            mem_we    <= 1'b1;
            clr_ptr   <= clr_ptr + ADDR_BITS'(1);
            if (&clr_ptr)
               clr_active <= 1'b0;
         end else if (grant_fifo) begin
            mem_addr  <= fifo_head[EW-1:8];
            mem_wdata <= fifo_head[7:0];
            mem_we    <= 1'b1;
            rd_ptr    <= rd_ptr + 1'b1;
         end

         pix_rvalid <= mem_re;
         if (pix_rvalid)
            rdata_q <= mem_rdata;

         // One cycle behind the state so busy covers the final write cycle.
         busy <= clr_active | !fifo_empty;
      end
   end

endmodule

// File: doc/vga_bus_arbiter.md
# vga_bus_arbiter

Bus front end and memory arbiter for the mini VGA card. It captures CPU I/O writes (iorq/write/chipsel/data) into an address/control register file and a small write FIFO. It then shares one single-port synchronous video RAM between three users: pixel-generator line fetches, a hardware clear-screen sequencer, and CPU write drains. Pixel fetches always win, so the display never starves.

## Interface
- ADDR_BITS, 13, video RAM address width
- FIFO_DEPTH, 4, CPU write FIFO entries (power of two, ≥2)
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- iorq  in  1  CPU I/O request, asynchronous to clk
- write  in  1  CPU write strobe, asynchronous to clk
- chipsel  in  2  register select: 0 addr low, 1 addr high, 2 data, 3 control
- data  in  8  CPU write data
- prepline  in  1  high while the pixel generator prefetches the next line
- pix_req  in  1  pixel generator read request
- pix_addr  in  ADDR_BITS  pixel read address
- pix_gnt  out  1  read accepted this cycle (combinational, equals pix_req)
- pix_rdata  out  8  read data
- pix_rvalid  out  1  pix_rdata valid, one-cycle pulse per read
- mem_addr  out  ADDR_BITS  RAM address (registered)
- mem_wdata  out  8  RAM write data (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_re  out  1  RAM read enable (registered)
- mem_rdata  in  8  RAM read data, valid the cycle after mem_re
- display_en  out  1  control bit0
- busy  out  1  clear active or FIFO non-empty
- overflow  out  1  sticky FIFO-overflow flag

## Operation
- Bus capture: s = iorq & write goes through a 2-flop synchronizer. A rising edge of the synchronized s is one write event. chipsel/data are sampled on that event; they are stable for the whole strobe.
- Reg 0/1: load addr_ptr[7:0] / addr_ptr[ADDR_BITS-1:8]. Extra high bits are ignored.
- Reg 2: push {addr_ptr, data} into the FIFO, then addr_ptr increments modulo 2^ADDR_BITS.
  - FIFO full with no pop this cycle: drop the entry and set overflow. addr_ptr still increments.
  - FIFO full with a pop this cycle: accept the entry.
- Reg 3: bit0 → display_en. bit1 = 1 starts a clear; ignored if a clear is already active. bit7 = 1 clears overflow.
- Arbiter, evaluated each cycle, at most one RAM op, in priority order:
  1. pix_req: issue a read at pix_addr.
  2. Clear active and !prepline: write 0x00 at clr_ptr, then clr_ptr++. Clear ends after writing 2^ADDR_BITS-1; clr_ptr returns to 0.
  3. FIFO non-empty and !prepline: pop and write the entry.
  4. Otherwise idle: mem_we = mem_re = 0.
- FIFO writes queued during a clear drain after the clear completes. They are not lost.
- pix_rdata captures mem_rdata in the cycle pix_rvalid is high and holds it afterwards.

## Timing
- Reset values: mem_addr 0, mem_wdata 0, mem_we 0, mem_re 0, pix_rvalid 0, pix_rdata 0, display_en 0, busy 0, overflow 0. Also addr_ptr 0, FIFO empty, clear idle, synchronizers 0.
- Bus latency: the synchronized edge is seen on the 3rd clk rising edge after s rises. The register update or FIFO push happens on that edge.
  - A FIFO entry can reach mem_we on the following cycle at the earliest.
- Pixel read, req at cycle N: pix_gnt high at N; mem_re/mem_addr high at N+1; pix_rvalid/pix_rdata at N+2. Back-to-back reads sustain one per cycle.
- Clear duration: exactly 2^ADDR_BITS write cycles with no pix_req and prepline low. Each pix_req cycle or prepline cycle stalls the clear by one cycle.
- busy rises the cycle after the clear starts or the first push. It falls the cycle after the last clear write or last pop issues.
- Reset asserted mid-clear or mid-drain: immediate abort. FIFO contents are discarded; mem_we drops asynchronously.

## Test plan
- Reset: assert rst mid-run → all outputs 0 immediately. After release, writing reg2 without loading the address → write lands at address 0.
- Address + autoinc: reg0=0x34, reg1=0x12, reg2=0xAA, reg2=0xBB → mem writes (0x1234,0xAA), then (0x1235,0xBB). Repeat at addr 0x1FFF → second write wraps to 0x0000.
- Priority: FIFO holds 2 entries, pix_req high for 5 cycles → 5 reads with pix_rvalid at N+2..N+6. No mem_we until pix_req drops, then 2 writes. prepline high with the FIFO non-empty → no writes until prepline falls.
- Overflow: FIFO_DEPTH=4, prepline held high, 5 reg2 writes → 4 entries kept, overflow=1. Reg3 bit7 → overflow=0.
- Clear: ADDR_BITS=4, reg3=0x02 → 16 writes of 0x00 to addresses 0..15, busy high throughout. A reg2 write during the clear executes after address 15.
- Reset mid-clear: assert rst after 5 clear writes → mem_we=0 and busy=0. No further writes after release.
